// File: rtl/mlp_layer_sequencer.sv
// Purpose : time-multiplexes one shared MAC across every neuron of a dense MLP layer.
// Latency : one neuron every 3 cycles plus the MAC latency (7 cycles with a 4-cycle MAC); results are registered.
// Backpres: none; start is ignored while busy, and a silent MAC is aborted by a watchdog.
//
// Ports:
//   clk, reset_n                  clock and async active-low reset
//   start, x_in                   layer start request and the layer input vector (latched on accept)
//   busy, err                     layer in progress / sticky MAC-timeout flag
//   w_rd_en, w_rd_addr            weight-memory read strobe and neuron index
//   w_rd_data, b_rd_data          weight row and bias, valid one cycle after w_rd_en
//   mac_start, mac_x,
//   mac_weights, mac_bias         MAC launch pulse and its registered operands
//   mac_output, mac_done          MAC result and its completion pulse
//   y_valid, y_idx, y_data        one registered result per neuron
//   layer_done                    pulses with the last y_valid of the layer
module mlp_layer_sequencer #(
    parameter int NUM_FEATURES  = 4,
    parameter int NUM_NEURONS   = 8,
    parameter int FP_TOTAL_BITS = 16,
    parameter int FP_FRAC_BITS  = 8,
    parameter int RELU_EN       = 1,
    parameter int MAC_TIMEOUT   = 15,
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              start,
    input  logic signed [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0] x_in,
    output logic                                              busy,
    output logic                                              w_rd_en,
    output logic        [IDX_W-1:0]                           w_rd_addr,
    input  logic signed [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0] w_rd_data,
    input  logic signed [FP_TOTAL_BITS-1:0]                   b_rd_data,
    output logic                                              mac_start,
    output logic signed [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0] mac_x,
    output logic signed [NUM_FEATURES-1:0][FP_TOTAL_BITS-1:0] mac_weights,
    output logic signed [FP_TOTAL_BITS-1:0]                   mac_bias,
    input  logic signed [FP_TOTAL_BITS-1:0]                   mac_output,
    input  logic                                              mac_done,
    output logic                                              y_valid,
    output logic        [IDX_W-1:0]                           y_idx,
    output logic signed [FP_TOTAL_BITS-1:0]                   y_data,
    output logic                                              layer_done,
    output logic                                              err
);

    // The fractional width only describes the Q format the MAC works in;
    // this block never rescales, so it is just sanity-checked here.
    if (NUM_NEURONS < 1 || MAC_TIMEOUT < 1 ||
        FP_FRAC_BITS < 0 || FP_FRAC_BITS >= FP_TOTAL_BITS) begin : g_bad_params
        $error("mlp_layer_sequencer: illegal parameter combination");
    end

    localparam int WD_W = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_N  = IDX_W'(NUM_NEURONS - 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MAC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        RUN,
        WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] n;
    logic [WD_W-1:0]  wd;
    logic             end_pulse;   // high in the cycle after a layer finishes or aborts
    logic             accept;
    logic             take;
    logic             timeout;
    logic             last_n;

    assign last_n = (n == LAST_N);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        take      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                // The cycle carrying layer_done / the abort is already IDLE,
                // but a start arriving alongside it is still treated as too early.
                if (start && !end_pulse) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = RUN;
            RUN:   state_nxt = WAIT;
            WAIT: begin
                // A done arriving on the final watchdog cycle still counts.
                if (mac_done) begin
                    take      = 1'b1;
                    state_nxt = last_n ? IDLE : FETCH;
                end else if (wd == WD_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign w_rd_en   = (state == FETCH);
    assign w_rd_addr = (state == FETCH) ? n : '0;
    assign mac_start = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_x       <= '0;
            mac_weights <= '0;
            mac_bias    <= '0;
            n           <= '0;
            wd          <= '0;
            err         <= 1'b0;
            y_valid     <= 1'b0;
            y_idx       <= '0;
            y_data      <= '0;
            layer_done  <= 1'b0;
            end_pulse   <= 1'b0;
        end else begin
            y_valid    <= take;
            layer_done <= take && last_n;
            end_pulse  <= (take && last_n) || timeout;

            if (accept) begin
                mac_x <= x_in;
                n     <= '0;
                err   <= 1'b0;
            end

            if (state == LOAD) begin
                mac_weights <= w_rd_data;
                mac_bias    <= b_rd_data;
            end

            if (state == RUN) begin
                wd <= '0;
            end else if (state == WAIT) begin
                wd <= wd + 1'b1;
            end

            if (take) begin
                // ReLU only inspects the sign bit; the value is otherwise untouched.
                y_data <= (RELU_EN != 0 && mac_output[FP_TOTAL_BITS-1]) ? '0 : mac_output;
                y_idx  <= n;
                if (!last_n) begin
                    n <= n + 1'b1;
                end
            end

            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Purpose : directed self-checking bench for mlp_layer_sequencer with a 4-cycle MAC model
// Latency : checks are taken on the falling edge; cycle 0 is the cycle after the accepted start edge.
// Backpres: none; every wait is a bounded cycle loop.
module tb_mlp_layer_sequencer;

    logic                     clk;
    logic                     reset_n;
    logic                     start;
    logic signed [3:0][15:0]  x_in;
    logic signed [3:0][15:0]  w_rd_data;
    logic signed [15:0]       b_rd_data;
    logic signed [15:0]       mac_output;
    logic                     mac_done;

    logic                     busy, w_rd_en, mac_start, y_valid, layer_done, err;
    logic [2:0]               w_rd_addr, y_idx;
    logic signed [3:0][15:0]  mac_x, mac_weights;
    logic signed [15:0]       mac_bias, y_data;

    // second instance: two neurons, ReLU disabled, shares memory/MAC traffic
    logic                     busy1, w_rd_en1, mac_start1, y_valid1, layer_done1, err1;
    logic [0:0]               w_rd_addr1, y_idx1;
    logic signed [3:0][15:0]  mac_x1, mac_weights1;
    logic signed [15:0]       mac_bias1, y_data1;

    int errors = 0;
    int checks = 0;

    logic signed [3:0][15:0] mem_w [8];
    logic signed [15:0]      mem_b [8];
    logic [3:0]              dpipe;
    logic signed [15:0]      mac_res;
    logic                    mac_en;

    logic signed [3:0][15:0] X0;
    logic signed [3:0][15:0] XALT;

    mlp_layer_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .x_in(x_in),
        .busy(busy), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .b_rd_data(b_rd_data),
        .mac_start(mac_start), .mac_x(mac_x), .mac_weights(mac_weights),
        .mac_bias(mac_bias), .mac_output(mac_output), .mac_done(mac_done),
        .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data),
        .layer_done(layer_done), .err(err)
    );

    mlp_layer_sequencer #(.NUM_NEURONS(2), .RELU_EN(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .x_in(x_in),
        .busy(busy1), .w_rd_en(w_rd_en1), .w_rd_addr(w_rd_addr1),
        .w_rd_data(w_rd_data), .b_rd_data(b_rd_data),
        .mac_start(mac_start1), .mac_x(mac_x1), .mac_weights(mac_weights1),
        .mac_bias(mac_bias1), .mac_output(mac_output), .mac_done(mac_done),
        .y_valid(y_valid1), .y_idx(y_idx1), .y_data(y_data1),
        .layer_done(layer_done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous weight memory: data one cycle after the read strobe
    always @(posedge clk) begin
        if (w_rd_en) begin
            w_rd_data <= mem_w[w_rd_addr];
            b_rd_data <= mem_b[w_rd_addr];
        end
    end

    function automatic logic signed [15:0] mac_calc(input logic signed [3:0][15:0] x,
                                                    input logic signed [3:0][15:0] w,
                                                    input logic signed [15:0] b);
        int acc;
        acc = 0;
        for (int i = 0; i < 4; i++) acc += $signed(x[i]) * $signed(w[i]);
        acc = (acc >>> 8) + $signed(b);
        return acc[15:0];
    endfunction

    // 4-cycle MAC: done appears 4 edges after mac_start is sampled
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dpipe   <= '0;
            mac_res <= '0;
        end else begin
            dpipe <= {dpipe[2:0], mac_start};
            if (mac_start) mac_res <= mac_calc(mac_x, mac_weights, mac_bias);
        end
    end
    assign mac_done   = dpipe[3] & mac_en;
    assign mac_output = mac_res;

    task automatic apply_reset();
        start   = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input logic signed [3:0][15:0] x);
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic mem_layer();
        for (int k = 0; k < 8; k++) begin
            mem_w[k] = {4{16'sh0100}};
            mem_b[k] = 16'(k * 256);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        mac_en  = 1'b1;
        x_in    = X0;
        mem_layer();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, w_rd_en, mac_start, y_valid, layer_done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {busy, w_rd_en, mac_start, y_valid, layer_done, err});
        end
        checks++;
        if (mac_x !== '0 || mac_weights !== '0 || mac_bias !== '0 || y_data !== '0 || y_idx !== '0 || w_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_regs got x=%h w=%h b=%h y=%h idx=%0d addr=%0d want all 0",
                     mac_x, mac_weights, mac_bias, y_data, y_idx, w_rd_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_relu();
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            mem_w[k] = {4{16'sh0100}};
            mem_b[k] = 16'sh0000;
        end
        mem_w[1] = {4{16'shFF00}};
        mem_b[1] = 16'sh0100;
        do_start(X0);
        for (int i = 0; i <= 57; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL relu_busy0 got %b want 1", busy); end
            end
            if (i == 2) begin
                checks++;
                if (mac_start !== 1'b1) begin errors++; $display("FAIL relu_mac_start2 got %b want 1", mac_start); end
            end
            if (i == 7) begin
                checks++;
                if ({y_valid, y_idx, y_data} !== {1'b1, 3'd0, 16'h0280}) begin
                    errors++;
                    $display("FAIL neuron0 got v=%b idx=%0d y=%h want v=1 idx=0 y=0280", y_valid, y_idx, y_data);
                end
            end
            if (i == 14) begin
                checks++;
                if ({y_valid, y_idx, y_data} !== {1'b1, 3'd1, 16'h0000}) begin
                    errors++;
                    $display("FAIL relu_on got v=%b idx=%0d y=%h want v=1 idx=1 y=0000", y_valid, y_idx, y_data);
                end
                checks++;
                if ({y_valid1, y_idx1, y_data1, layer_done1} !== {1'b1, 1'b1, 16'hFE80, 1'b1}) begin
                    errors++;
                    $display("FAIL relu_off got v=%b idx=%0d y=%h ld=%b want v=1 idx=1 y=fe80 ld=1",
                             y_valid1, y_idx1, y_data1, layer_done1);
                end
            end
        end
    endtask

    task automatic test_full_layer();
        logic ev, ew, ems;
        apply_reset();
        mem_layer();
        do_start(X0);
        for (int i = 0; i <= 57; i++) begin
            @(negedge clk);
            ev  = (i > 0) && (i % 7 == 0) && (i <= 56);
            ew  = (i % 7 == 0) && (i < 56);
            ems = (i % 7 == 2) && (i < 56);
            checks++;
            if (y_valid !== ev) begin errors++; $display("FAIL full_y_valid cyc %0d got %b want %b", i, y_valid, ev); end
            if (ev) begin
                checks++;
                if (y_idx !== 3'(i / 7 - 1) || y_data !== 16'(16'h0280 + (i / 7 - 1) * 256)) begin
                    errors++;
                    $display("FAIL full_y cyc %0d got idx=%0d y=%h want idx=%0d y=%h", i, y_idx, y_data,
                             i / 7 - 1, 16'(16'h0280 + (i / 7 - 1) * 256));
                end
            end
            checks++;
            if (layer_done !== (i == 56)) begin errors++; $display("FAIL full_layer_done cyc %0d got %b want %b", i, layer_done, i == 56); end
            checks++;
            if (w_rd_en !== ew || (ew && w_rd_addr !== 3'(i / 7))) begin
                errors++;
                $display("FAIL full_rd cyc %0d got en=%b addr=%0d want en=%b addr=%0d", i, w_rd_en, w_rd_addr, ew, i / 7);
            end
            checks++;
            if (mac_start !== ems) begin errors++; $display("FAIL full_mac_start cyc %0d got %b want %b", i, mac_start, ems); end
            if (i == 55 || i == 56 || i == 57) begin
                checks++;
                if (busy !== (i == 55)) begin errors++; $display("FAIL full_busy cyc %0d got %b want %b", i, busy, i == 55); end
            end
            // start coincident with layer_done must be dropped
            if (i == 56) begin x_in = XALT; start = 1'b1; end
            if (i == 57) start = 1'b0;
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_layer();
        mac_en = 1'b0;
        do_start(X0);
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (y_valid !== 1'b0 || layer_done !== 1'b0) begin
                errors++;
                $display("FAIL to_no_result cyc %0d got v=%b ld=%b want 0 0", i, y_valid, layer_done);
            end
            if (i == 17 || i == 18) begin
                checks++;
                if ({busy, err} !== ((i == 17) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL to_abort cyc %0d got busy=%b err=%b want %b", i, busy, err, (i == 17) ? 2'b10 : 2'b01);
                end
            end
        end
        mac_en = 1'b1;
        do_start(X0);
        for (int i = 0; i <= 56; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %b want 0", err); end
            end
            if (i == 56) begin
                checks++;
                if ({layer_done, y_valid, y_idx, y_data} !== {1'b1, 1'b1, 3'd7, 16'h0980}) begin
                    errors++;
                    $display("FAIL to_recover got ld=%b v=%b idx=%0d y=%h want 1 1 7 0980", layer_done, y_valid, y_idx, y_data);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        apply_reset();
        mem_layer();
        do_start(X0);
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            if (i == 5 || i == 22) begin
                checks++;
                if (mac_x !== X0) begin errors++; $display("FAIL ign_mac_x cyc %0d got %h want %h", i, mac_x, X0); end
            end
            if (i > 0 && i % 7 == 0) begin
                checks++;
                if (y_valid !== 1'b1 || y_data !== 16'(16'h0280 + (i / 7 - 1) * 256)) begin
                    errors++;
                    $display("FAIL ign_y cyc %0d got v=%b y=%h want v=1 y=%h", i, y_valid, y_data, 16'(16'h0280 + (i / 7 - 1) * 256));
                end
            end
            if (i == 3 || i == 20) begin x_in = XALT; start = 1'b1; end
            if (i == 4 || i == 21) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_layer();
        do_start(X0);
        for (int i = 0; i <= 25; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, w_rd_en, mac_start, y_valid, layer_done, err} !== 6'b0 ||
            mac_x !== '0 || mac_weights !== '0 || mac_bias !== '0 || y_data !== '0 || y_idx !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b x=%h w=%h b=%h y=%h idx=%0d want all 0",
                     busy, mac_x, mac_weights, mac_bias, y_data, y_idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(X0);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (w_rd_en !== 1'b1 || w_rd_addr !== 3'd0) begin
                    errors++;
                    $display("FAIL mid_restart_rd got en=%b addr=%0d want 1 0", w_rd_en, w_rd_addr);
                end
            end
            if (i == 7) begin
                checks++;
                if ({y_valid, y_idx, y_data} !== {1'b1, 3'd0, 16'h0280}) begin
                    errors++;
                    $display("FAIL mid_restart_y got v=%b idx=%0d y=%h want 1 0 0280", y_valid, y_idx, y_data);
                end
            end
        end
    endtask

    initial begin
        X0   = {16'sh0080, 16'shFF00, 16'sh0200, 16'sh0100};
        XALT = {4{16'sh7F00}};
        test_reset();
        test_relu();
        test_full_layer();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
